// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for 1024x768 @ 60 Hz (65 MHz pixel clock).
// First stage of the video pipeline: every downstream draw stage takes its
// pixel counters and blanking/sync flags from here.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   en         pixel advance enable; when low all state and outputs hold
//   hcount     horizontal pixel index, 0..HOR_TOTAL-1
//   vcount     vertical line index, 0..VER_TOTAL-1
//   hblnk      high when hcount >= HOR_ACTIVE
//   vblnk      high when vcount >= VER_ACTIVE
//   hsync      horizontal sync pulse
//   vsync      vertical sync pulse
//   sof        one-cycle start-of-frame strobe (not raised by reset)
//   frame_cnt  completed-frame counter, wraps 65535 -> 0
//
// Optional macro VGA_TIMING_NEG_SYNC_EN: when defined, hsync/vsync are
// active-low (idle 1, including reset); otherwise active-high (idle 0).

package vga_pkg;
  localparam int HOR_TOTAL_TIME = 1344;
  localparam int HOR_PIXELS     = 1024;
  localparam int HOR_SYNC_START = 1048;
  localparam int HOR_SYNC_TIME  = 136;
  localparam int VER_TOTAL_TIME = 806;
  localparam int VER_PIXELS     = 768;
  localparam int VER_SYNC_START = 771;
  localparam int VER_SYNC_TIME  = 6;
endpackage

module vga_timing #(
  parameter int HOR_TOTAL      = vga_pkg::HOR_TOTAL_TIME,
  parameter int HOR_ACTIVE     = vga_pkg::HOR_PIXELS,
  parameter int HOR_SYNC_START = vga_pkg::HOR_SYNC_START,
  parameter int HOR_SYNC_LEN   = vga_pkg::HOR_SYNC_TIME,
  parameter int VER_TOTAL      = vga_pkg::VER_TOTAL_TIME,
  parameter int VER_ACTIVE     = vga_pkg::VER_PIXELS,
  parameter int VER_SYNC_START = vga_pkg::VER_SYNC_START,
  parameter int VER_SYNC_LEN   = vga_pkg::VER_SYNC_TIME
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblnk,
  output logic        vblnk,
  output logic        hsync,
  output logic        vsync,
  output logic        sof,
  output logic [15:0] frame_cnt
);

`ifdef VGA_TIMING_NEG_SYNC_EN
  localparam logic SYNC_ACTIVE = 1'b0;
`else
  localparam logic SYNC_ACTIVE = 1'b1;
`endif

  localparam logic [10:0] H_LAST = 11'(HOR_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(VER_TOTAL - 1);

  // Geometry sanity checks, evaluated at elaboration.
  if (!(HOR_ACTIVE < HOR_SYNC_START)) begin : g_chk_h_active
    $error("vga_timing: HOR_ACTIVE must be below HOR_SYNC_START");
  end
  if (!(HOR_SYNC_START + HOR_SYNC_LEN <= HOR_TOTAL)) begin : g_chk_h_sync
    $error("vga_timing: horizontal sync window exceeds HOR_TOTAL");
  end
  if (!(VER_ACTIVE < VER_SYNC_START)) begin : g_chk_v_active
    $error("vga_timing: VER_ACTIVE must be below VER_SYNC_START");
  end
  if (!(VER_SYNC_START + VER_SYNC_LEN <= VER_TOTAL)) begin : g_chk_v_sync
    $error("vga_timing: vertical sync window exceeds VER_TOTAL");
  end
  if (!(HOR_TOTAL <= 2048 && VER_TOTAL <= 2048)) begin : g_chk_width
    $error("vga_timing: totals do not fit the 11-bit counters");
  end

  // Half-open window test [start, start+len), unsigned.
  function automatic logic in_window(input logic [10:0] val, input int start, input int len);
    return (int'(val) >= start) && (int'(val) < start + len);
  endfunction

  function automatic logic sync_level(input logic active);
    return active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  endfunction

  logic        h_last;
  logic        v_last;
  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;

  // Next counter position; flags are derived from it so they register
  // together with the counters and carry no skew.
  always_comb begin
    h_last     = (hcount == H_LAST);
    v_last     = (vcount == V_LAST);
    hcount_nxt = hcount + 11'd1;
    vcount_nxt = vcount;
    if (h_last) begin
      hcount_nxt = '0;
      vcount_nxt = v_last ? 11'd0 : vcount + 11'd1;
    end
  end

  // Stage p0: registered counters, flags and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount    <= '0;
      vcount    <= '0;
      hblnk     <= 1'b0;
      vblnk     <= 1'b0;
      hsync     <= ~SYNC_ACTIVE;
      vsync     <= ~SYNC_ACTIVE;
      sof       <= 1'b0;
      frame_cnt <= '0;
    end else if (en) begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
      hblnk  <= (int'(hcount_nxt) >= HOR_ACTIVE);
      vblnk  <= (int'(vcount_nxt) >= VER_ACTIVE);
      hsync  <= sync_level(in_window(hcount_nxt, HOR_SYNC_START, HOR_SYNC_LEN));
      vsync  <= sync_level(in_window(vcount_nxt, VER_SYNC_START, VER_SYNC_LEN));
      // Strobe only on a genuine frame wrap, never on the reset (0,0).
      sof    <= h_last && v_last;
      if (h_last && v_last) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing, using a reduced raster so full frames stay short.
// The reference model maps "number of enabled edges since reset" directly to
// the expected raster position and flags with plain arithmetic.
module tb_vga_timing;

  localparam int HT  = 40;
  localparam int HA  = 24;
  localparam int HSS = 28;
  localparam int HSL = 6;
  localparam int VT  = 20;
  localparam int VA  = 12;
  localparam int VSS = 14;
  localparam int VSL = 3;
  localparam int FL  = HT * VT;

`ifdef VGA_TIMING_NEG_SYNC_EN
  localparam logic ACT = 1'b0;
`else
  localparam logic ACT = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;
  logic        sof;
  logic [15:0] frame_cnt;

  typedef logic [42:0] vec_t;
  vec_t obs;
  vec_t exp_v;
  assign obs = {hcount, vcount, hblnk, vblnk, hsync, vsync, sof, frame_cnt};

  int n_asserts = 0;
  int n_fail    = 0;
  int n         = 0;   // enabled edges since last reset

  vga_timing #(
    .HOR_TOTAL(HT), .HOR_ACTIVE(HA), .HOR_SYNC_START(HSS), .HOR_SYNC_LEN(HSL),
    .VER_TOTAL(VT), .VER_ACTIVE(VA), .VER_SYNC_START(VSS), .VER_SYNC_LEN(VSL)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hcount(hcount), .vcount(vcount), .hblnk(hblnk), .vblnk(vblnk),
    .hsync(hsync), .vsync(vsync), .sof(sof), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs after k enabled edges since reset.
  function automatic vec_t model(input int k);
    int p, h, v;
    logic hs, vs, s;
    p  = k % FL;
    h  = p % HT;
    v  = p / HT;
    hs = (h >= HSS && h < HSS + HSL) ? ACT : ~ACT;
    vs = (v >= VSS && v < VSS + VSL) ? ACT : ~ACT;
    s  = (k > 0) && (p == 0);
    return {11'(h), 11'(v), logic'(h >= HA), logic'(v >= VA), hs, vs, s, 16'(k / FL)};
  endfunction

  task automatic tick(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e && !rst) n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0);
    tick(1'b1);
    n = 0;
    exp_v = model(0);
    n_asserts++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state got %h expected %h", obs, exp_v);
    end
    n_asserts++;
    if ({hsync, vsync} !== {2{~ACT}}) begin
      n_fail++;
      $display("FAIL reset_sync_idle got %b%b expected %b%b", hsync, vsync, ~ACT, ~ACT);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_line();
    int hs_cnt;
    int rise_h;
    do_reset();
    hs_cnt = 0;
    rise_h = -1;
    for (int i = 0; i < HT; i++) begin
      tick(1'b1);
      exp_v = model(n);
      n_asserts++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL first_line n=%0d got %h expected %h", n, obs, exp_v);
      end
      if (hsync === ACT) hs_cnt++;
      if (hblnk === 1'b1 && rise_h < 0) rise_h = int'(hcount);
    end
    n_asserts++;
    if (rise_h != HA) begin
      n_fail++;
      $display("FAIL hblnk_rise got hcount=%0d expected %0d", rise_h, HA);
    end
    n_asserts++;
    if (hs_cnt != HSL) begin
      n_fail++;
      $display("FAIL hsync_width got %0d expected %0d", hs_cnt, HSL);
    end
    n_asserts++;
    if (hcount !== 11'd0 || vcount !== 11'd1) begin
      n_fail++;
      $display("FAIL line_wrap got h=%0d v=%0d expected h=0 v=1", hcount, vcount);
    end
  endtask

  task automatic test_full_frame();
    int sof_cnt, vs_cnt, act_cnt, vb_cnt, errs;
    do_reset();
    sof_cnt = 0; vs_cnt = 0; act_cnt = 0; vb_cnt = 0; errs = 0;
    for (int i = 0; i < FL; i++) begin
      tick(1'b1);
      exp_v = model(n);
      n_asserts++;
      if (obs !== exp_v) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL full_frame n=%0d got %h expected %h", n, obs, exp_v);
      end
      if (sof === 1'b1) sof_cnt++;
      if (vsync === ACT) vs_cnt++;
      if (vblnk === 1'b1) vb_cnt++;
      if (hblnk === 1'b0 && vblnk === 1'b0) act_cnt++;
    end
    n_asserts++;
    if (sof_cnt != 1 || sof !== 1'b1 || hcount !== 11'd0 || vcount !== 11'd0) begin
      n_fail++;
      $display("FAIL sof_once got count=%0d sof=%b h=%0d v=%0d expected 1,1,0,0",
               sof_cnt, sof, hcount, vcount);
    end
    n_asserts++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL frame_cnt_one got %0d expected 1", frame_cnt);
    end
    n_asserts++;
    if (vs_cnt != VSL * HT) begin
      n_fail++;
      $display("FAIL vsync_cycles got %0d expected %0d", vs_cnt, VSL * HT);
    end
    n_asserts++;
    if (vb_cnt != (VT - VA) * HT) begin
      n_fail++;
      $display("FAIL vblnk_cycles got %0d expected %0d", vb_cnt, (VT - VA) * HT);
    end
    n_asserts++;
    if (act_cnt != HA * VA) begin
      n_fail++;
      $display("FAIL active_cycles got %0d expected %0d", act_cnt, HA * VA);
    end
  endtask

  task automatic test_en_toggle();
    int cycles, errs;
    do_reset();
    cycles = 0;
    errs = 0;
    while (n < 2 * FL && cycles < 20000) begin
      tick(logic'($urandom_range(0, 1)));
      cycles++;
      exp_v = model(n);
      n_asserts++;
      if (obs !== exp_v) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL en_toggle n=%0d got %h expected %h", n, obs, exp_v);
      end
    end
    n_asserts++;
    if (n != 2 * FL || frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL en_toggle_end got n=%0d frame_cnt=%0d expected %0d, 2", n, frame_cnt, 2 * FL);
    end
    // sof sits high here; it must hold while en is low.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      n_asserts++;
      if (sof !== 1'b1 || hcount !== 11'd0) begin
        n_fail++;
        $display("FAIL sof_hold got sof=%b h=%0d expected 1, 0", sof, hcount);
      end
    end
    tick(1'b1);
    n_asserts++;
    if (sof !== 1'b0 || hcount !== 11'd1) begin
      n_fail++;
      $display("FAIL sof_release got sof=%b h=%0d expected 0, 1", sof, hcount);
    end
  endtask

  task automatic test_mid_reset();
    int target;
    do_reset();
    target = 10 * HT + 20;
    while (n < target) tick(1'b1);
    n_asserts++;
    if (hcount !== 11'd20 || vcount !== 11'd10) begin
      n_fail++;
      $display("FAIL mid_position got h=%0d v=%0d expected 20,10", hcount, vcount);
    end
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    n = 0;
    exp_v = model(0);
    n_asserts++;
    if (obs !== exp_v || sof !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got %h expected %h", obs, exp_v);
    end
    tick(1'b1);
    exp_v = model(n);
    n_asserts++;
    if (obs !== exp_v || hcount !== 11'd1) begin
      n_fail++;
      $display("FAIL restart got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_full_frame();
    test_en_toggle();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
